// File: rtl/damage_resolver.sv
// Responder for the core's damage handshake: sweeps every lane, trades hits between the
// front left and right units in unit RAM, then holds done until the core acks.
//
// state  | meaning
// IDLE   | waiting for start; kills from the last pass held
// RD_L   | address left unit of current lane
// RD_R   | address right unit; left word arrives and is latched
// WAIT_R | right word arrives; both new HP values computed from pre-hit stats
// WR_L   | write back left HP (skipped for an empty slot)
// WR_R   | write back right HP (skipped for an empty slot); advance lane or finish
// DONE   | done high until ack
module damage_resolver #(
   parameter int NUM_LANES = 4,
   parameter int LANE_W    = 2,
   parameter int HP_W      = 8,
   parameter int STAT_W    = 6,
   parameter int MIN_DMG   = 1
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       start,
   input  logic                       ack,
   output logic                       done,
   output logic                       busy,
   output logic [LANE_W:0]            mem_addr,
   output logic                       mem_we,
   output logic [HP_W+2*STAT_W-1:0]   mem_wdata,
   input  logic [HP_W+2*STAT_W-1:0]   mem_rdata,
   output logic [LANE_W:0]            kills_l,
   output logic [LANE_W:0]            kills_r
);

   localparam int WORD_W = HP_W + 2*STAT_W;
   localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(NUM_LANES - 1);
   localparam logic [LANE_W:0]   KILL_ONE  = (LANE_W+1)'(1);

   typedef enum logic [2:0] {
      IDLE, RD_L, RD_R, WAIT_R, WR_L, WR_R, DONE
   } state_t;

   state_t state, nextState;

   logic [LANE_W-1:0] lane;
   logic [WORD_W-1:0] lWord, rWord;
   logic [HP_W-1:0]   newL, newR;
   logic [STAT_W-1:0] dmgL, dmgR;

   function automatic logic [HP_W-1:0] hpOf(input logic [WORD_W-1:0] w);
      return w[WORD_W-1 -: HP_W];
   endfunction

   function automatic logic [STAT_W-1:0] atkOf(input logic [WORD_W-1:0] w);
      return w[2*STAT_W-1 -: STAT_W];
   endfunction

   function automatic logic [STAT_W-1:0] armOf(input logic [WORD_W-1:0] w);
      return w[STAT_W-1:0];
   endfunction

   // A dead attacker deals nothing; a live one always deals at least chip damage.
   function automatic logic [STAT_W-1:0] calcDmg(input logic [HP_W-1:0]   atkHp,
                                                 input logic [STAT_W-1:0] atk,
                                                 input logic [STAT_W-1:0] arm);
      if (atkHp == '0)
         return '0;
      else if (atk > arm)
         return atk - arm;
      else
         return STAT_W'(MIN_DMG);
   endfunction

   function automatic logic [HP_W-1:0] satSub(input logic [HP_W-1:0]   hp,
                                              input logic [STAT_W-1:0] dmg);
      logic [HP_W-1:0] d;
      d = HP_W'(dmg);
      return (hp > d) ? hp - d : '0;
   endfunction

   // Right word is taken straight off the RAM bus in WAIT_R.
   assign dmgR = calcDmg(hpOf(lWord), atkOf(lWord), armOf(mem_rdata));
   assign dmgL = calcDmg(hpOf(mem_rdata), atkOf(mem_rdata), armOf(lWord));

   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         state <= IDLE;
      else
         state <= nextState;
   end

   always_comb begin
      nextState = state;
      case (state)
         IDLE:    if (start) nextState = RD_L;
         RD_L:    nextState = RD_R;
         RD_R:    nextState = WAIT_R;
         WAIT_R:  nextState = WR_L;
         WR_L:    nextState = WR_R;
         WR_R:    nextState = (lane == LAST_LANE) ? DONE : RD_L;
         DONE:    if (ack) nextState = IDLE;
         default: nextState = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         lane    <= '0;
         lWord   <= '0;
         rWord   <= '0;
         newL    <= '0;
         newR    <= '0;
         kills_l <= '0;
         kills_r <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  lane    <= '0;
                  kills_l <= '0;
                  kills_r <= '0;
               end
            end
            RD_R:   lWord <= mem_rdata;
            WAIT_R: begin
               rWord <= mem_rdata;
               newL  <= satSub(hpOf(lWord), dmgL);
               newR  <= satSub(hpOf(mem_rdata), dmgR);
            end
            WR_L: begin
               if (hpOf(lWord) != '0 && newL == '0)
                  kills_l <= kills_l + KILL_ONE;
            end
            WR_R: begin
               if (hpOf(rWord) != '0 && newR == '0)
                  kills_r <= kills_r + KILL_ONE;
               if (lane != LAST_LANE)
                  lane <= lane + LANE_W'(1);
            end
            default: ;
         endcase
      end
   end

   always_comb begin
      done      = (state == DONE);
      busy      = (state != IDLE) && (state != DONE);
      mem_addr  = '0;
      mem_we    = 1'b0;
      mem_wdata = '0;
      case (state)
         RD_L: mem_addr = {1'b0, lane};
         RD_R: mem_addr = {1'b1, lane};
         WR_L: begin
            mem_addr = {1'b0, lane};
            if (hpOf(lWord) != '0) begin
               mem_we    = 1'b1;
               mem_wdata = {newL, lWord[2*STAT_W-1:0]};
            end
         end
         WR_R: begin
            mem_addr = {1'b1, lane};
            if (hpOf(rWord) != '0) begin
               mem_we    = 1'b1;
               mem_wdata = {newR, rWord[2*STAT_W-1:0]};
            end
         end
         default: ;
      endcase
   end

endmodule
